spart_frame_sched: RTL and testbench
====================================

Name: spart_frame_sched

Overview:
- Sole master of the SPART processor-side bus.
- After reset, programs the baud divisor.
- Then schedules byte accesses between a receive framer and a transmit framer. The receive framer assembles FRAME_BYTES-byte packets (status/x/y pairs) into one wide word. The transmit framer serialises a host-supplied frame.
- Sits between the SPART and the game logic. One SPART bus access per cycle at most.

Parameters:
- BAUD_DIV, 16'd650: divisor written to the SPART at startup (100 MHz, 9600 baud).
- FRAME_BYTES, 6: bytes per RX and TX frame. Frame word width W = 8*FRAME_BYTES.
- RX_TIMEOUT, 20'd1000000: inter-byte idle limit in clk cycles. Used only with SPART_RX_TIMEOUT_EN.

Ports:
- clk  in  1  100 MHz clock.
- rst  in  1  reset; asynchronous, active-high.
- iocs  out  1  SPART chip select, one-cycle strobe per access.
- iorw  out  1  1 = read, 0 = write.
- ioaddr  out  2  00 data, 01 status, 10 divisor low, 11 divisor high.
- bus_out  out  8  write data to SPART.
- bus_in  in  8  read data from SPART; valid in the iocs&iorw cycle.
- rda  in  1  SPART receive data available.
- tbr  in  1  SPART transmit buffer ready.
- tx_req  in  1  host requests a frame send; sampled only while tx_busy=0.
- tx_data  in  W  frame to send; byte 0 = bits [W-1:W-8].
- tx_busy  out  1  TX frame in progress.
- rx_frame  out  W  last complete RX frame; first byte received in [W-1:W-8].
- rx_valid  out  1  one-cycle pulse on rx_frame update.
- cfg_done  out  1  divisor programmed; stays high until reset.
- rx_err  out  1  one-cycle pulse on RX timeout; constant 0 without the feature.

Behaviour:
- All outputs are registered.
- Reset values:
  - iocs=0, iorw=1, ioaddr=00, bus_out=0.
  - tx_busy=0, rx_frame=0, rx_valid=0, cfg_done=0, rx_err=0.
  - Byte counters=0, last_grant=TX.
- Reset mid-frame discards partial RX/TX frames and reprograms the divisor.
- FSM states: CFG_LO, CFG_HI, IDLE, GAP.
  - CFG_LO: write BAUD_DIV[7:0] to addr 10 (iocs=1, iorw=0). Go to CFG_HI.
  - CFG_HI: write BAUD_DIV[15:8] to addr 11. Set cfg_done. Go to GAP.
  - IDLE: arbitrate as below. On a grant, perform the access this cycle, then go to GAP. With no grant, stay in IDLE with iocs=0.
  - GAP: one dead cycle (iocs=0) so rda/tbr reflect the prior access. Always go to IDLE.
- Arbitration, IDLE only:
  - rx_want = rda.
  - tx_want = tx_busy & tbr.
  - Only one wants: grant it.
  - Both want: grant the one not equal to last_grant (alternating). last_grant updates on every grant.
  - Worst-case rda service latency is 4 cycles.
- RX access: read addr 00, iorw=1.
  - Shift bus_in into the RX shift register; rx_cnt++.
  - When rx_cnt reaches FRAME_BYTES-1 and is read: rx_frame <= assembled word; rx_valid=1 next cycle; rx_cnt wraps to 0.
- TX access: write addr 00, iorw=0, bus_out = current top byte of the TX shift register; tx_cnt++.
  - After byte FRAME_BYTES-1: tx_busy clears the following cycle and tx_cnt wraps to 0.
- TX accept:
  - tx_req=1 with tx_busy=0 latches tx_data and sets tx_busy next cycle.
  - tx_req while busy is ignored. The host must hold it until tx_busy rises.
  - tx_req before cfg_done is accepted, but no byte is written until cfg_done.
- rda and tbr are ignored until cfg_done.
- RX and TX frames progress independently. Byte interleaving never corrupts either frame.

Optional Feature:
- Macro: SPART_RX_TIMEOUT_EN.
- Defined:
  - A 20-bit idle counter runs while rx_cnt≠0. It resets on each RX read.
  - On reaching RX_TIMEOUT: rx_cnt <= 0, partial frame dropped, rx_err pulses 1 cycle, rx_frame unchanged.
- Undefined: no counter; a partial frame waits indefinitely; rx_err tied to 0.

Decomposition:
- Package spart_pkg holds:
  - SPART address constants (ADDR_DATA=2'b00, ADDR_STATUS=2'b01, ADDR_DB_LO=2'b10, ADDR_DB_HI=2'b11).
  - iorw encodings READ=1, WRITE=0.
  - FSM state encodings.
  - Defaults for BAUD_DIV and FRAME_BYTES.
- Sub-module spart_byte_shifter is natural. It is a W-bit shift register with byte counter, load, shift-in, shift-out and wrap/done flag, instantiated once for RX and once for TX.

Test Plan:
- Reset release -> cycle 1 write 8'h8A to addr 10; cycle 2 write 8'h02 to addr 11; cfg_done=1 from cycle 3; no iocs before.
- rda pulses with bytes 01,02,03,04,05,06 -> six reads at addr 00 each followed by GAP; rx_frame=48'h010203040506; rx_valid exactly one pulse.
- tx_req with tx_data=48'hA1B2C3D4E5F6, tbr=1 always -> writes A1,B2,C3,D4,E5,F6 on alternating cycles; tx_busy high from accept to one cycle after F6.
- Both tx_busy&tbr and rda held continuously -> grants alternate RX/TX; both frames complete intact.
- Assert rst after 3 RX bytes -> all outputs return to reset values; after reconfig, six new bytes 11..16 give rx_frame=48'h111213141516.
- With SPART_RX_TIMEOUT_EN and RX_TIMEOUT=100: 2 bytes then 100 idle cycles -> rx_err pulse; next 6 bytes form a clean frame.

Source files
------------

// File: rtl/spart_pkg.sv
// Shared constants and types for the SPART frame scheduler.
package spart_pkg;

  // SPART processor-side register map
  localparam logic [1:0] ADDR_DATA   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DB_LO  = 2'b10;
  localparam logic [1:0] ADDR_DB_HI  = 2'b11;

  // iorw encodings
  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  // Build defaults
  localparam logic [15:0] DEF_BAUD_DIV    = 16'd650;
  localparam int unsigned DEF_FRAME_BYTES = 6;

  typedef enum logic [1:0] {
    ST_CFG_LO = 2'b00,
    ST_CFG_HI = 2'b01,
    ST_IDLE   = 2'b10,
    ST_GAP    = 2'b11
  } sched_state_t;

  typedef enum logic {
    GRANT_RX = 1'b0,
    GRANT_TX = 1'b1
  } grant_t;

endpackage

// File: rtl/spart_byte_shifter.sv
// Byte-wide shift register with frame byte counter. Shifts left by one
// byte per i_shift (new byte enters at the bottom, oldest leaves at the top);
// the counter wraps after BYTES shifts. i_clr drops a partial frame.
module spart_byte_shifter #(
  parameter int unsigned BYTES = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clr,
  input  logic                 i_load,
  input  logic [8*BYTES-1:0]   i_load_data,
  input  logic                 i_shift,
  input  logic [7:0]           i_byte,
  output logic [8*BYTES-1:0]   o_data,
  output logic                 o_last,
  output logic                 o_pend
);

  localparam int unsigned W  = 8 * BYTES;
  localparam int unsigned CW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BYTES - 1);

  logic [W-1:0]  r_data;
  logic [CW-1:0] r_cnt;

  // Shift register and byte counter; clear beats load beats shift
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_cnt  <= '0;
    end else if (i_clr) begin
      r_data <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_data <= i_load_data;
      r_cnt  <= '0;
    end else if (i_shift) begin
      r_data <= {r_data[W-9:0], i_byte};
      r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
    end
  end

  assign o_data = r_data;
  assign o_last = (r_cnt == LAST);
  assign o_pend = (r_cnt != '0);

endmodule

// File: rtl/spart_frame_sched.sv
// SPART bus master: programs the baud divisor after reset, then alternates
// single-byte accesses between an RX frame assembler and a TX frame
// serialiser, with a dead cycle after every access.
// Optional build macro: SPART_RX_TIMEOUT_EN (inter-byte RX idle timeout).
module spart_frame_sched
  import spart_pkg::*;
#(
  parameter logic [15:0] BAUD_DIV    = DEF_BAUD_DIV,
  parameter int unsigned FRAME_BYTES = DEF_FRAME_BYTES,
  parameter logic [19:0] RX_TIMEOUT  = 20'd1000000
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       iocs,
  output logic                       iorw,
  output logic [1:0]                 ioaddr,
  output logic [7:0]                 bus_out,
  input  logic [7:0]                 bus_in,
  input  logic                       rda,
  input  logic                       tbr,
  input  logic                       tx_req,
  input  logic [8*FRAME_BYTES-1:0]   tx_data,
  output logic                       tx_busy,
  output logic [8*FRAME_BYTES-1:0]   rx_frame,
  output logic                       rx_valid,
  output logic                       cfg_done,
  output logic                       rx_err
);

  localparam int unsigned W = 8 * FRAME_BYTES;

  sched_state_t r_state;
  grant_t       r_last_grant;
  logic         r_iocs;
  logic         r_iorw;
  logic [1:0]   r_ioaddr;
  logic [7:0]   r_bus_out;
  logic         r_cfg_done;
  logic         r_tx_busy;
  logic         r_tx_fin;
  logic [W-1:0] r_rx_frame;
  logic         r_rx_valid;

  logic [W-1:0] w_rx_data;
  logic [W-1:0] w_tx_data;
  logic         w_rx_last;
  logic         w_rx_pend;
  logic         w_tx_last;
  logic         w_tx_pend;
  logic         w_rx_cap;
  logic         w_rx_drop;
  logic         w_rx_want;
  logic         w_tx_want;
  logic         w_grant_rx;
  logic         w_idle;
  logic         w_do_rx;
  logic         w_do_tx;
  logic         w_tx_load;

  // The read data is valid during the registered iocs&iorw cycle, so the
  // capture happens on the edge that ends that cycle (state is GAP then).
  assign w_rx_cap   = r_iocs & (r_iorw == READ) & (r_ioaddr == ADDR_DATA);
  assign w_rx_want  = rda & r_cfg_done;
  assign w_tx_want  = r_tx_busy & tbr & r_cfg_done;
  assign w_grant_rx = w_rx_want & (~w_tx_want | (r_last_grant == GRANT_TX));
  assign w_idle     = (r_state == ST_IDLE);
  assign w_do_rx    = w_idle & w_grant_rx;
  assign w_do_tx    = w_idle & w_tx_want & ~w_grant_rx;
  assign w_tx_load  = tx_req & ~r_tx_busy;

  spart_byte_shifter #(.BYTES(FRAME_BYTES)) u_rx_shift (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (w_rx_drop),
    .i_load      (1'b0),
    .i_load_data ('0),
    .i_shift     (w_rx_cap),
    .i_byte      (bus_in),
    .o_data      (w_rx_data),
    .o_last      (w_rx_last),
    .o_pend      (w_rx_pend)
  );

  spart_byte_shifter #(.BYTES(FRAME_BYTES)) u_tx_shift (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (1'b0),
    .i_load      (w_tx_load),
    .i_load_data (tx_data),
    .i_shift     (w_do_tx),
    .i_byte      (8'h00),
    .o_data      (w_tx_data),
    .o_last      (w_tx_last),
    .o_pend      (w_tx_pend)
  );

  // Bus FSM: divisor programming, arbitration and one dead cycle per access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_CFG_LO;
      r_last_grant <= GRANT_TX;
      r_iocs       <= 1'b0;
      r_iorw       <= READ;
      r_ioaddr     <= ADDR_DATA;
      r_bus_out    <= '0;
      r_cfg_done   <= 1'b0;
    end else begin
      r_iocs <= 1'b0;
      case (r_state)
        ST_CFG_LO: begin
          r_iocs    <= 1'b1;
          r_iorw    <= WRITE;
          r_ioaddr  <= ADDR_DB_LO;
          r_bus_out <= BAUD_DIV[7:0];
          r_state   <= ST_CFG_HI;
        end
        ST_CFG_HI: begin
          r_iocs     <= 1'b1;
          r_iorw     <= WRITE;
          r_ioaddr   <= ADDR_DB_HI;
          r_bus_out  <= BAUD_DIV[15:8];
          r_cfg_done <= 1'b1;
          r_state    <= ST_GAP;
        end
        ST_IDLE: begin
          if (w_do_rx) begin
            r_iocs       <= 1'b1;
            r_iorw       <= READ;
            r_ioaddr     <= ADDR_DATA;
            r_last_grant <= GRANT_RX;
            r_state      <= ST_GAP;
          end else if (w_do_tx) begin
            r_iocs       <= 1'b1;
            r_iorw       <= WRITE;
            r_ioaddr     <= ADDR_DATA;
            r_bus_out    <= w_tx_data[W-1 -: 8];
            r_last_grant <= GRANT_TX;
            r_state      <= ST_GAP;
          end
        end
        ST_GAP:  r_state <= ST_IDLE;
        default: r_state <= ST_CFG_LO;
      endcase
    end
  end

  // TX frame ownership: busy from accept until the cycle after the last byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_busy <= 1'b0;
      r_tx_fin  <= 1'b0;
    end else begin
      r_tx_fin <= w_do_tx & w_tx_last;
      if (w_tx_load)
        r_tx_busy <= 1'b1;
      else if (r_tx_fin)
        r_tx_busy <= 1'b0;
    end
  end

  // RX frame publication on the capture of the final byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_frame <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= w_rx_cap & w_rx_last;
      if (w_rx_cap & w_rx_last)
        r_rx_frame <= {w_rx_data[W-9:0], bus_in};
    end
  end

`ifdef SPART_RX_TIMEOUT_EN
  logic [19:0] r_idle_cnt;
  logic        r_rx_err;

  // A capture on the same edge as expiry keeps the frame alive
  assign w_rx_drop = w_rx_pend & ~w_rx_cap & (r_idle_cnt == RX_TIMEOUT - 20'd1);

  // Inter-byte idle counter; only runs while a partial frame is held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idle_cnt <= '0;
      r_rx_err   <= 1'b0;
    end else begin
      r_rx_err <= w_rx_drop;
      if (w_rx_cap || !w_rx_pend || w_rx_drop)
        r_idle_cnt <= '0;
      else
        r_idle_cnt <= r_idle_cnt + 20'd1;
    end
  end

  assign rx_err = r_rx_err;

  logic w_unused;
  assign w_unused = &{1'b0, w_rx_data[W-1 -: 8], w_tx_data[W-9:0], w_tx_pend};
`else
  assign w_rx_drop = 1'b0;
  assign rx_err    = 1'b0;

  logic w_unused;
  assign w_unused = &{1'b0, w_rx_data[W-1 -: 8], w_tx_data[W-9:0], w_tx_pend,
                      w_rx_pend, RX_TIMEOUT};
`endif

  assign iocs     = r_iocs;
  assign iorw     = r_iorw;
  assign ioaddr   = r_ioaddr;
  assign bus_out  = r_bus_out;
  assign cfg_done = r_cfg_done;
  assign tx_busy  = r_tx_busy;
  assign rx_frame = r_rx_frame;
  assign rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spart_frame_sched.sv
// Directed testbench for spart_frame_sched with a small behavioural SPART
// model (RX byte queue, write log).
`timescale 1ns/1ps
module tb_spart_frame_sched;

  localparam int W = 48;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         iocs, iorw;
  logic [1:0]   ioaddr;
  logic [7:0]   bus_out;
  logic [7:0]   bus_in = 8'h00;
  logic         rda = 1'b0;
  logic         tbr = 1'b1;
  logic         tx_req = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         tx_busy;
  logic [W-1:0] rx_frame;
  logic         rx_valid, cfg_done, rx_err;

  always #5 clk = ~clk;

  spart_frame_sched #(
    .BAUD_DIV    (16'd650),
    .FRAME_BYTES (6),
    .RX_TIMEOUT  (20'd100)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .iocs     (iocs),
    .iorw     (iorw),
    .ioaddr   (ioaddr),
    .bus_out  (bus_out),
    .bus_in   (bus_in),
    .rda      (rda),
    .tbr      (tbr),
    .tx_req   (tx_req),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .rx_frame (rx_frame),
    .rx_valid (rx_valid),
    .cfg_done (cfg_done),
    .rx_err   (rx_err)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // SPART model state and observation logs
  logic [7:0] rx_q[$];
  bit         pop_pend = 0;
  int         reads = 0;
  logic [7:0] wr_data[$];
  int         wr_cyc[$];
  logic       wr_busy[$];
  logic       acc_kind[$];   // 1 = data read, 0 = data write
  int         gap_viol = 0;
  int         valid_pulses = 0;
  int         err_pulses = 0;
  bit         prev_data_acc = 0;

  always @(posedge clk) cyc++;

  // SPART model: pops a byte one cycle after its read so rda drops before
  // the next arbitration edge, logs every data access at negedge.
  always @(negedge clk) begin
    if (pop_pend) begin
      if (rx_q.size() > 0) void'(rx_q.pop_front());
      pop_pend = 0;
    end
    if (iocs && ioaddr == 2'b00) begin
      if (prev_data_acc) gap_viol++;
      if (iorw) begin
        reads++;
        pop_pend = 1;
        acc_kind.push_back(1'b1);
      end else begin
        wr_data.push_back(bus_out);
        wr_cyc.push_back(cyc);
        wr_busy.push_back(tx_busy);
        acc_kind.push_back(1'b0);
      end
    end
    prev_data_acc = iocs && (ioaddr == 2'b00);
    if (rx_valid) valid_pulses++;
    if (rx_err) err_pulses++;
    rda    = (rx_q.size() != 0);
    bus_in = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_logs();
    wr_data.delete();
    wr_cyc.delete();
    wr_busy.delete();
    acc_kind.delete();
    reads = 0;
    valid_pulses = 0;
    gap_viol = 0;
  endtask

  task automatic wait_rx_valid(input string name);
    int n;
    n = 0;
    while (rx_valid !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    vectors++;
    if (rx_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_rx_valid_timeout: rx_valid=%b after %0d cycles, required 1", name, rx_valid, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(3);
    vectors++;
    if ({iocs, iorw, ioaddr, bus_out, tx_busy, rx_valid, cfg_done, rx_err} !==
        {1'b0, 1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_outputs: cs=%b rw=%b a=%b d=%h busy=%b v=%b cfg=%b err=%b, required 0 1 00 00 0 0 0 0",
               iocs, iorw, ioaddr, bus_out, tx_busy, rx_valid, cfg_done, rx_err);
    end
    vectors++;
    if (rx_frame !== 48'h0) begin
      miscompares++;
      $display("FAIL reset_rx_frame: got %h, required 0", rx_frame);
    end
    rst = 1'b0;
    clear_logs();
    step();
    vectors++;
    if ({iocs, iorw, ioaddr, bus_out, cfg_done} !== {1'b1, 1'b0, 2'b10, 8'h8A, 1'b0}) begin
      miscompares++;
      $display("FAIL cfg_lo: cs=%b rw=%b a=%b d=%h cfg=%b, required 1 0 10 8a 0", iocs, iorw, ioaddr, bus_out, cfg_done);
    end
    step();
    vectors++;
    if ({iocs, iorw, ioaddr, bus_out} !== {1'b1, 1'b0, 2'b11, 8'h02}) begin
      miscompares++;
      $display("FAIL cfg_hi: cs=%b rw=%b a=%b d=%h, required 1 0 11 02", iocs, iorw, ioaddr, bus_out);
    end
    step();
    vectors++;
    if ({iocs, cfg_done} !== 2'b01) begin
      miscompares++;
      $display("FAIL cfg_done: cs=%b cfg=%b, required cs=0 cfg=1", iocs, cfg_done);
    end
    step(3);
    vectors++;
    if (acc_kind.size() != 0) begin
      miscompares++;
      $display("FAIL cfg_no_data_access: got %0d data accesses, required 0", acc_kind.size());
    end
  endtask

  task automatic test_rx_frame();
    clear_logs();
    for (int i = 1; i <= 6; i++) rx_q.push_back(8'(i));
    wait_rx_valid("rx");
    vectors++;
    if (rx_frame !== 48'h010203040506) begin
      miscompares++;
      $display("FAIL rx_frame: got %h, required 010203040506", rx_frame);
    end
    step(20);
    vectors++;
    if (reads != 6) begin
      miscompares++;
      $display("FAIL rx_read_count: got %0d, required 6", reads);
    end
    vectors++;
    if (valid_pulses != 1) begin
      miscompares++;
      $display("FAIL rx_valid_pulses: got %0d, required 1", valid_pulses);
    end
    vectors++;
    if (gap_viol != 0) begin
      miscompares++;
      $display("FAIL rx_gap: got %0d back-to-back accesses, required 0", gap_viol);
    end
  endtask

  task automatic test_tx_frame();
    logic [7:0] exp_b[6];
    int n;
    exp_b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
    clear_logs();
    tx_data = 48'hA1B2C3D4E5F6;
    tx_req  = 1'b1;
    step();
    vectors++;
    if (tx_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL tx_accept: tx_busy=%b, required 1", tx_busy);
    end
    // a request while busy must not disturb the frame in flight
    tx_data = 48'hFFEEDDCCBBAA;
    step(2);
    tx_req = 1'b0;
    n = 0;
    while (tx_busy === 1'b1 && n < 100) begin
      step();
      n++;
    end
    vectors++;
    if (tx_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL tx_busy_clear_timeout: tx_busy=%b, required 0", tx_busy);
    end
    step(4);
    vectors++;
    if (wr_data.size() != 6) begin
      miscompares++;
      $display("FAIL tx_write_count: got %0d, required 6", wr_data.size());
    end
    for (int i = 0; i < 6 && i < wr_data.size(); i++) begin
      vectors++;
      if (wr_data[i] !== exp_b[i]) begin
        miscompares++;
        $display("FAIL tx_byte%0d: got %h, required %h", i, wr_data[i], exp_b[i]);
      end
    end
    for (int i = 1; i < wr_cyc.size(); i++) begin
      vectors++;
      if (wr_cyc[i] - wr_cyc[i-1] != 2) begin
        miscompares++;
        $display("FAIL tx_spacing%0d: got %0d cycles, required 2", i, wr_cyc[i] - wr_cyc[i-1]);
      end
    end
    if (wr_busy.size() == 6) begin
      vectors++;
      if (wr_busy[5] !== 1'b1) begin
        miscompares++;
        $display("FAIL tx_busy_last_byte: got %b, required 1", wr_busy[5]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b[6];
    logic       exp_k;
    int n;
    exp_b = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
    clear_logs();
    for (int i = 0; i < 6; i++) rx_q.push_back(8'h21 + 8'(i));
    tx_data = 48'h313233343536;
    tx_req  = 1'b1;
    step();
    tx_req = 1'b0;
    n = 0;
    while ((valid_pulses == 0 || tx_busy === 1'b1) && n < 300) begin
      step();
      n++;
    end
    step(4);
    vectors++;
    if (rx_frame !== 48'h212223242526) begin
      miscompares++;
      $display("FAIL b2b_rx_frame: got %h, required 212223242526", rx_frame);
    end
    vectors++;
    if (acc_kind.size() != 12) begin
      miscompares++;
      $display("FAIL b2b_access_count: got %0d, required 12", acc_kind.size());
    end
    for (int i = 0; i < 12 && i < acc_kind.size(); i++) begin
      exp_k = (i % 2 == 0);
      vectors++;
      if (acc_kind[i] !== exp_k) begin
        miscompares++;
        $display("FAIL b2b_grant%0d: got kind %b, required %b (1=rx)", i, acc_kind[i], exp_k);
      end
    end
    for (int i = 0; i < 6 && i < wr_data.size(); i++) begin
      vectors++;
      if (wr_data[i] !== exp_b[i]) begin
        miscompares++;
        $display("FAIL b2b_tx_byte%0d: got %h, required %h", i, wr_data[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    clear_logs();
    rx_q.push_back(8'h41);
    rx_q.push_back(8'h42);
    rx_q.push_back(8'h43);
    n = 0;
    while (reads < 3 && n < 100) begin
      step();
      n++;
    end
    step();
    rst = 1'b1;
    rx_q.delete();
    pop_pend = 0;
    step(2);
    vectors++;
    if ({iocs, iorw, ioaddr, bus_out, tx_busy, rx_valid, cfg_done, rx_err} !==
        {1'b0, 1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL midrst_outputs: cs=%b rw=%b a=%b d=%h busy=%b v=%b cfg=%b err=%b, required 0 1 00 00 0 0 0 0",
               iocs, iorw, ioaddr, bus_out, tx_busy, rx_valid, cfg_done, rx_err);
    end
    vectors++;
    if (rx_frame !== 48'h0) begin
      miscompares++;
      $display("FAIL midrst_rx_frame: got %h, required 0", rx_frame);
    end
    rst = 1'b0;
    step(4);
    vectors++;
    if (cfg_done !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_reconfig: cfg_done=%b, required 1", cfg_done);
    end
    clear_logs();
    for (int i = 0; i < 6; i++) rx_q.push_back(8'h11 + 8'(i));
    wait_rx_valid("midrst");
    vectors++;
    if (rx_frame !== 48'h111213141516) begin
      miscompares++;
      $display("FAIL midrst_new_frame: got %h, required 111213141516", rx_frame);
    end
  endtask

  task automatic test_rx_idle();
    int n;
    clear_logs();
    err_pulses = 0;
    rx_q.push_back(8'h51);
    rx_q.push_back(8'h52);
    n = 0;
    while (reads < 2 && n < 100) begin
      step();
      n++;
    end
    step(150);
`ifdef SPART_RX_TIMEOUT_EN
    vectors++;
    if (err_pulses != 1) begin
      miscompares++;
      $display("FAIL timeout_err_pulses: got %0d, required 1", err_pulses);
    end
    vectors++;
    if (rx_frame !== 48'h111213141516) begin
      miscompares++;
      $display("FAIL timeout_frame_kept: got %h, required 111213141516", rx_frame);
    end
    for (int i = 0; i < 6; i++) rx_q.push_back(8'h61 + 8'(i));
    wait_rx_valid("timeout");
    vectors++;
    if (rx_frame !== 48'h616263646566) begin
      miscompares++;
      $display("FAIL timeout_clean_frame: got %h, required 616263646566", rx_frame);
    end
`else
    vectors++;
    if (err_pulses != 0) begin
      miscompares++;
      $display("FAIL idle_no_err: got %0d rx_err pulses, required 0", err_pulses);
    end
    for (int i = 0; i < 4; i++) rx_q.push_back(8'h61 + 8'(i));
    wait_rx_valid("idle");
    vectors++;
    if (rx_frame !== 48'h515261626364) begin
      miscompares++;
      $display("FAIL idle_partial_kept: got %h, required 515261626364", rx_frame);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_rx_frame();
    test_tx_frame();
    test_back_to_back();
    test_reset_mid_frame();
    test_rx_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
